// File: rtl/dual_issue_ctrl.sv
// Issue/hazard controller for a dual-issue pipeline: pair splitting, load-use stalls, branch squash.
// Optional macro DUAL_MEM_EN lets two memory operations issue as a pair.
module dual_issue_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  COND_AL = 4'hE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Valid1D,
  input  logic             i_Valid2D,
  input  logic [3:0]       i_Rn1D,
  input  logic [3:0]       i_Rm1D,
  input  logic [3:0]       i_Rn2D,
  input  logic [3:0]       i_Rm2D,
  input  logic             i_UseRn1D,
  input  logic             i_UseRm1D,
  input  logic             i_UseRn2D,
  input  logic             i_UseRm2D,
  input  logic [3:0]       i_Rd1D,
  input  logic [3:0]       i_Rd2D,
  input  logic             i_RegWrite1D,
  input  logic             i_RegWrite2D,
  input  logic             i_MemtoReg1D,
  input  logic             i_MemtoReg2D,
  input  logic             i_MemWrite1D,
  input  logic             i_MemWrite2D,
  input  logic             i_FlagWrite1D,
  input  logic             i_Branch1D,
  input  logic [3:0]       i_Cond2D,
  input  logic [3:0]       i_Rd1E,
  input  logic [3:0]       i_Rd2E,
  input  logic             i_RegWrite1E,
  input  logic             i_RegWrite2E,
  input  logic             i_MemtoReg1E,
  input  logic             i_MemtoReg2E,
  input  logic             i_BrTaken1E,
  input  logic             i_BrTaken2E,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_FlushD,
  output logic             o_Flush1E,
  output logic             o_Flush2E,
  output logic             o_Kill2E,
  output logic             o_Split,
  output logic [CNT_W-1:0] o_IssueCnt,
  output logic [CNT_W-1:0] o_SplitCnt,
  output logic [CNT_W-1:0] o_StallCnt
);

  localparam int unsigned SumW = CNT_W + 1;

  typedef enum logic {StPair, StSplit} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, split_cnt_q, stall_cnt_q;

  logic ld1e, ld2e, lu1, lu2, lu, br;
  logic raw, waw, flg, mem_conf, pc;
  logic split_ev, stall_ev;
  logic [1:0] issue_inc;

  function automatic logic src_hit(input logic [3:0] r, input logic use_r,
                                   input logic ld1, input logic [3:0] rd1,
                                   input logic ld2, input logic [3:0] rd2);
    return use_r & ((ld1 & (r == rd1)) | (ld2 & (r == rd2)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [SumW-1:0] sum;
    sum = {1'b0, cnt} + SumW'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    ld1e = i_RegWrite1E & i_MemtoReg1E;
    ld2e = i_RegWrite2E & i_MemtoReg2E;
    lu1  = i_Valid1D & (src_hit(i_Rn1D, i_UseRn1D, ld1e, i_Rd1E, ld2e, i_Rd2E) |
                        src_hit(i_Rm1D, i_UseRm1D, ld1e, i_Rd1E, ld2e, i_Rd2E));
    lu2  = i_Valid2D & (src_hit(i_Rn2D, i_UseRn2D, ld1e, i_Rd1E, ld2e, i_Rd2E) |
                        src_hit(i_Rm2D, i_UseRm2D, ld1e, i_Rd1E, ld2e, i_Rd2E));
    // In SPLIT slot 1 has already issued; only the pending slot 2 can still hit a load.
    lu   = (state_q == StPair) ? (lu1 | lu2) : lu2;
    br   = i_BrTaken1E | i_BrTaken2E;

    raw = i_RegWrite1D & ((i_UseRn2D & (i_Rd1D == i_Rn2D)) | (i_UseRm2D & (i_Rd1D == i_Rm2D)));
    waw = i_RegWrite1D & i_RegWrite2D & (i_Rd1D == i_Rd2D);
    flg = i_FlagWrite1D & (i_Cond2D != COND_AL);
`ifdef DUAL_MEM_EN
    mem_conf = 1'b0;
`else
    mem_conf = (i_MemtoReg1D | i_MemWrite1D) & (i_MemtoReg2D | i_MemWrite2D);
`endif
    pc = (state_q == StPair) & i_Valid1D & i_Valid2D & (raw | waw | flg | i_Branch1D | mem_conf);

    o_StallF  = 1'b0;
    o_StallD  = 1'b0;
    o_FlushD  = 1'b0;
    o_Flush1E = 1'b0;
    o_Flush2E = 1'b0;
    o_Kill2E  = 1'b0;
    state_d   = state_q;
    split_ev  = 1'b0;
    stall_ev  = 1'b0;

    if (rst) begin
      o_Flush1E = 1'b1;
      o_Flush2E = 1'b1;
      state_d   = StPair;
    end else if (br) begin
      o_FlushD  = 1'b1;
      o_Flush1E = 1'b1;
      o_Flush2E = 1'b1;
      o_Kill2E  = i_BrTaken1E;
      state_d   = StPair;
    end else if (lu) begin
      o_StallF  = 1'b1;
      o_StallD  = 1'b1;
      o_Flush1E = 1'b1;
      o_Flush2E = 1'b1;
      stall_ev  = 1'b1;
    end else if (pc) begin
      o_StallF  = 1'b1;
      o_StallD  = 1'b1;
      o_Flush2E = 1'b1;
      state_d   = StSplit;
      split_ev  = 1'b1;
    end else if (state_q == StSplit) begin
      o_Flush1E = 1'b1;
      state_d   = StPair;
    end else begin
      o_Flush1E = ~i_Valid1D;
      o_Flush2E = ~i_Valid2D;
    end

    o_Split   = (state_q == StSplit) & ~rst;
    issue_inc = {1'b0, ~o_Flush1E} + {1'b0, ~o_Flush2E};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPair;
      issue_cnt_q <= '0;
      split_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= sat_add(issue_cnt_q, issue_inc);
      split_cnt_q <= sat_add(split_cnt_q, {1'b0, split_ev});
      stall_cnt_q <= sat_add(stall_cnt_q, {1'b0, stall_ev});
    end
  end

  assign o_IssueCnt = issue_cnt_q;
  assign o_SplitCnt = split_cnt_q;
  assign o_StallCnt = stall_cnt_q;

endmodule
